// File: rtl/inst_buffer_pkg.sv
// Shared widths and record layouts for the ID-side instruction buffer.
// The fetch bus and buffer entries are packed structs so their fields can be named.
package inst_buffer_pkg;

    localparam int IF_TO_ID_WD = 66;
    localparam int IB_ENTRY_WD = 64;
    localparam int IB_DEPTH    = 16;
    localparam int IB_SLACK    = 4;

    typedef struct packed {
        logic        discard;
        logic        ce;
        logic [31:0] pc_start;
        logic [31:0] pc_base;
    } fetch_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ib_entry_t;

    // Decode can never take more than two instructions per cycle.
    function automatic logic [1:0] clip_pop(input logic [1:0] req);
        return (req == 2'd3) ? 2'd2 : req;
    endfunction

endpackage

// File: rtl/inst_buffer_ib_ram.sv
// Circular-buffer storage: two adjacent write ports and two asynchronous read ports.
// Port 0 always writes the lower of the two consecutive entries.
module ib_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int AW    = 4
) (
    input  logic                   clk,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr,
    input  logic [IB_ENTRY_WD-1:0] wdata0,
    input  logic [IB_ENTRY_WD-1:0] wdata1,
    input  logic [AW-1:0]          raddr,
    output logic [IB_ENTRY_WD-1:0] rdata0,
    output logic [IB_ENTRY_WD-1:0] rdata1
);

    logic [IB_ENTRY_WD-1:0] mem [DEPTH];
    logic [AW-1:0]          waddr1;
    logic [AW-1:0]          raddr1;

    assign waddr1 = waddr + AW'(1);
    assign raddr1 = raddr + AW'(1);

    always_ff @(posedge clk) begin
        if (we0) mem[waddr]  <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_buffer.sv
// ID-side receiver for paired 64-bit instruction fetch: pairs request metadata with
// the SRAM data one cycle later, queues surviving words and presents two per cycle.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH,
    parameter int AW    = 4,
    parameter int SLACK = IB_SLACK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [IF_TO_ID_WD-1:0] fetch_bus,
    input  logic [63:0]            inst_sram_rdata,
    input  logic [1:0]             id_pop,
    output logic                   stall_req,
    output logic                   inst0_valid,
    output logic [31:0]            inst0_pc,
    output logic [31:0]            inst0,
    output logic                   inst1_valid,
    output logic [31:0]            inst1_pc,
    output logic [31:0]            inst1
);

    fetch_bus_t fb;
    assign fb = fetch_bus_t'(fetch_bus);

    logic          unused_pc_bits;
    assign unused_pc_bits = ^{fb.pc_start[31:3], fb.pc_start[1:0]};

    logic          pend_v;
    logic [31:0]   pend_base;
    logic          pend_off;

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_next, free;
    logic [1:0]    pop_req, pop, wr_req, wr_n;
    ib_entry_t     wentry0, wentry1, rentry0, rentry1;
    logic          kill;

    assign kill = rst | flush;

    always_comb begin
        pop_req = clip_pop(id_pop);
        pop     = (count < (AW+1)'(pop_req)) ? count[1:0] : pop_req;
        wr_req  = pend_v ? (pend_off ? 2'd1 : 2'd2) : 2'd0;
        free    = (AW+1)'(DEPTH) - count + (AW+1)'(pop);
        // Words that would overrun the read pointer are dropped rather than corrupting the queue.
        wr_n    = ((AW+1)'(wr_req) > free) ? free[1:0] : wr_req;
        count_next = count + (AW+1)'(wr_n) - (AW+1)'(pop);
        wentry0 = pend_off ? ib_entry_t'{pend_base + 32'd4, inst_sram_rdata[63:32]}
                           : ib_entry_t'{pend_base, inst_sram_rdata[31:0]};
        wentry1 = ib_entry_t'{pend_base + 32'd4, inst_sram_rdata[63:32]};
    end

    ib_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk    (clk),
        .we0    (~kill && wr_n != 2'd0),
        .we1    (~kill && wr_n == 2'd2),
        .waddr  (wr_ptr),
        .wdata0 (wentry0),
        .wdata1 (wentry1),
        .raddr  (rd_ptr),
        .rdata0 (rentry0),
        .rdata1 (rentry1)
    );

    // Capture stage: request metadata waits here for its SRAM data.
    always_ff @(posedge clk) begin
        pend_base <= fb.pc_base;
        pend_off  <= fb.pc_start[2];
        if (kill) pend_v <= 1'b0;
        else      pend_v <= fb.ce & ~fb.discard;
    end

    // Write/pop stage: queue pointers, occupancy and registered back-pressure.
    always_ff @(posedge clk) begin
        if (kill) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            stall_req <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr + AW'(pop);
            wr_ptr    <= wr_ptr + AW'(wr_n);
            count     <= count_next;
            stall_req <= count_next > (AW+1)'(DEPTH - SLACK);
        end
    end

    always_ff @(posedge clk) begin
        if (!kill && pend_v) begin
            assert ((AW+1)'(wr_req) <= free)
            else $error("inst_buffer: write overran free space, words dropped");
        end
    end

    assign inst0_valid = (count != '0);
    assign inst1_valid = (count >= (AW+1)'(2));
    assign {inst0_pc, inst0} = inst0_valid ? rentry0 : '0;
    assign {inst1_pc, inst1} = inst1_valid ? rentry1 : '0;

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed scenarios then random traffic, compared every cycle
// against a queue-based model of the buffer contents.
module tb_inst_buffer;

    localparam int DEPTH = 16;
    localparam int SLACK = 4;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [65:0] fetch_bus;
    logic [63:0] inst_sram_rdata;
    logic [1:0]  id_pop;
    logic        stall_req, inst0_valid, inst1_valid;
    logic [31:0] inst0_pc, inst0, inst1_pc, inst1;

    logic        ce, discard;
    logic [31:0] pc_base, pc_start;
    assign fetch_bus = {discard, ce, pc_start, pc_base};

    inst_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .fetch_bus       (fetch_bus),
        .inst_sram_rdata (inst_sram_rdata),
        .id_pop          (id_pop),
        .stall_req       (stall_req),
        .inst0_valid     (inst0_valid),
        .inst0_pc        (inst0_pc),
        .inst0           (inst0),
        .inst1_valid     (inst1_valid),
        .inst1_pc        (inst1_pc),
        .inst1           (inst1)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of {pc, inst}, plus the one request awaiting its data.
    logic [63:0] q[$];
    logic        m_pend_v = 1'b0;
    logic [31:0] m_base   = '0;
    logic        m_off    = 1'b0;
    logic        m_stall  = 1'b0;
    int          m_ovf    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        if (q.size() < DEPTH) q.push_back({pc, ins});
        else m_ovf++;
    endtask

    task automatic model_edge();
        int np;
        if (rst || flush) begin
            q.delete();
            m_pend_v = 1'b0;
            m_stall  = 1'b0;
        end else begin
            np = (id_pop > 2'd2) ? 2 : int'(id_pop);
            if (np > q.size()) np = q.size();
            repeat (np) void'(q.pop_front());
            if (m_pend_v) begin
                if (!m_off) push(m_base, inst_sram_rdata[31:0]);
                push(m_base + 32'd4, inst_sram_rdata[63:32]);
            end
            m_stall  = q.size() > DEPTH - SLACK;
            m_pend_v = ce & ~discard;
        end
        m_base = pc_base;
        m_off  = pc_start[2];
    endtask

    task automatic compare();
        logic [63:0] e0, e1;
        e0 = (q.size() >= 1) ? q[0] : 64'd0;
        e1 = (q.size() >= 2) ? q[1] : 64'd0;
        check("stall_req",   64'(stall_req),   64'(m_stall));
        check("inst0_valid", 64'(inst0_valid), 64'(q.size() >= 1));
        check("inst1_valid", 64'(inst1_valid), 64'(q.size() >= 2));
        check("inst0",       {inst0_pc, inst0}, e0);
        check("inst1",       {inst1_pc, inst1}, e1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic c, input logic d, input logic [31:0] base, input logic off,
                         input logic [63:0] rd, input logic [1:0] p, input logic fl);
        ce              = c;
        discard         = d;
        pc_base         = base;
        pc_start        = base + (off ? 32'd4 : 32'd0);
        inst_sram_rdata = rd;
        id_pop          = p;
        flush           = fl;
    endtask

    initial begin
        logic [31:0] pc;
        logic        saw_stall;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        check("rst_inst0_valid", 64'(inst0_valid), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_inst0", {inst0_pc, inst0}, 64'd0);
        rst = 1'b0;

        // Aligned pair at the boot vector.
        drive(1, 0, 32'hbfc00000, 0, 64'h0, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, {32'h2, 32'h1}, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, 64'h0, 0, 0); cyc();
        check("t1_inst0", {inst0_pc, inst0}, {32'hbfc00000, 32'h1});
        check("t1_inst1", {inst1_pc, inst1}, {32'hbfc00004, 32'h2});

        // Entry at +4: only the upper word survives.
        drive(1, 0, 32'h80000008, 1, 64'h0, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, {32'hbb, 32'haa}, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, 64'h0, 2, 0); cyc();
        check("t2_inst0", {inst0_pc, inst0}, {32'h8000000c, 32'hbb});
        check("t2_inst1_valid", 64'(inst1_valid), 64'd0);

        // Discarded request leaves the queue untouched; the next one lands.
        drive(1, 1, 32'h90000000, 0, 64'h0, 0, 0); cyc();
        drive(1, 0, 32'h90000010, 0, {32'hdead, 32'hbeef}, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, {32'h44, 32'h33}, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, 64'h0, 1, 0); cyc();
        check("t3_inst0", {inst0_pc, inst0}, {32'h90000010, 32'h33});

        // Fetch every cycle with no decode; fetch honours stall_req.
        saw_stall = 1'b0;
        pc = 32'ha0000000;
        for (int i = 0; i < 24; i++) begin
            drive(~stall_req, 0, pc, 0, {$urandom, $urandom}, 0, 0);
            if (!stall_req) pc = pc + 32'd8;
            cyc();
            if (stall_req) saw_stall = 1'b1;
        end
        check("t4_stall_seen", 64'(saw_stall), 64'd1);
        check("t4_no_overflow", 64'(m_ovf), 64'd0);
        check("t4_full", 64'(q.size() <= DEPTH), 64'd1);

        // Drain to 5, then a 2-word write alongside a 2-pop keeps occupancy at 5.
        for (int i = 0; i < 16 && q.size() > 5; i++) begin
            drive(0, 0, 0, 0, 64'h0, (q.size() - 5 >= 2) ? 2'd2 : 2'd1, 0);
            cyc();
        end
        drive(1, 0, 32'hb0000000, 0, 64'h0, 0, 0); cyc();
        drive(0, 0, 32'h0, 0, {32'h5a5a, 32'ha5a5}, 2, 0); cyc();
        check("t5_count", 64'(q.size()), 64'd5);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 64'h0, 2, 0); cyc();
        end

        // Flush with a pair in flight at occupancy 7.
        drive(0, 0, 0, 0, 64'h0, 0, 1); cyc();
        drive(1, 0, 32'hc0000000, 0, {$urandom, $urandom}, 0, 0); cyc();
        drive(1, 0, 32'hc0000008, 0, {$urandom, $urandom}, 0, 0); cyc();
        drive(1, 0, 32'hc0000010, 0, {$urandom, $urandom}, 0, 0); cyc();
        drive(1, 0, 32'hc0000018, 1, {$urandom, $urandom}, 0, 0); cyc();
        drive(1, 0, 32'hc0000020, 0, {$urandom, $urandom}, 0, 0); cyc();
        check("t6_pre_count", 64'(q.size()), 64'd7);
        drive(1, 0, 32'hc0000028, 0, {$urandom, $urandom}, 0, 1); cyc();
        check("t6_inst0_valid", 64'(inst0_valid), 64'd0);
        check("t6_inst1_valid", 64'(inst1_valid), 64'd0);
        drive(0, 0, 0, 0, {$urandom, $urandom}, 0, 0); cyc();
        check("t6_late_dropped", 64'(inst0_valid), 64'd0);
        drive(1, 0, 32'hd0000000, 0, 64'h0, 0, 0); cyc();
        drive(0, 0, 0, 0, {32'h77, 32'h66}, 0, 0); cyc();
        check("t6_refill", {inst0_pc, inst0}, {32'hd0000000, 32'h66});

        // Random traffic with occasional flush and reset.
        pc = 32'h80000000;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive(~stall_req & ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                  pc, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0));
            pc = pc + 32'd8;
            cyc();
        end
        rst = 1'b0;
        check("rand_no_overflow", 64'(m_ovf), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
